// File: rtl/sccpu_mem_arbiter.sv
// sccpu_mem_arbiter: shares one single-ported unified memory between the CPU
// fetch port (i_*) and the load/store port (d_*). A fixed-priority arbiter
// drives a registered req/ack handshake to memory and returns a one-cycle ack.
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT cycles without m_ack (ack is returned with err=1 and rdata=0).
module sccpu_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned D_PRIORITY = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

  state_e        state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          grant_d, grant_i;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Fixed-priority grant decision, only consumed in IDLE.
  always_comb begin
    grant_d = d_req && (!i_req || (D_PRIORITY != 0));
    grant_i = i_req && !grant_d;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = i_ack_q;
    d_ack_d   = d_ack_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          state_d   = StBusyD;
        end else if (grant_i) begin
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          state_d   = StBusyI;
        end
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StBusyI, StBusyD: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = StDone;
          // Stores capture too; the value is simply not meaningful.
          if (state_q == StBusyI) begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          m_req_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
          if (state_q == StBusyI) begin
            i_rdata_d = '0;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        // Ack visible for exactly this cycle; requests are not looked at.
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);
`ifdef ARB_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_sccpu_mem_arbiter.sv
// Directed bench for sccpu_mem_arbiter. The bench plays the memory; expected
// acks are queued when a request is driven and popped when an ack appears.
// A second instance with D_PRIORITY=0 shares the inputs for the priority check.
module tb_sccpu_mem_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, m_req, m_we, stall, err;

  logic [31:0] i_rdata0, unused_d_rdata0, m_addr0, m_wdata0;
  logic        i_ack0, d_ack0, m_req0, m_we0, stall0, unused_err0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  sccpu_mem_arbiter #(.AW(32), .DW(32), .D_PRIORITY(1), .TIMEOUT(16)) u_dut (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall), .err(err)
  );

  sccpu_mem_arbiter #(.AW(32), .DW(32), .D_PRIORITY(0), .TIMEOUT(16)) u_dut0 (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata0), .i_ack(i_ack0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(unused_d_rdata0), .d_ack(d_ack0),
    .m_req(m_req0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall0), .err(unused_err0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic chk_data, input logic [31:0] rdata,
                          input logic e);
    exp_t x;
    x.is_d = is_d;
    x.chk_data = chk_data;
    x.rdata = rdata;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic expect_ack(input string tag);
    exp_t x;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=pending entry", tag);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_i_ack"}, 64'(i_ack), 64'(!x.is_d));
      chk({tag, "_d_ack"}, 64'(d_ack), 64'(x.is_d));
      if (x.chk_data) chk({tag, "_rdata"}, 64'(x.is_d ? d_rdata : i_rdata), 64'(x.rdata));
      chk({tag, "_err"}, 64'(err), 64'(x.err));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_m_req"}, 64'(m_req), 0);
    chk({tag, "_m_we"}, 64'(m_we), 0);
    chk({tag, "_m_addr"}, 64'(m_addr), 0);
    chk({tag, "_m_wdata"}, 64'(m_wdata), 0);
    chk({tag, "_i_rdata"}, 64'(i_rdata), 0);
    chk({tag, "_d_rdata"}, 64'(d_rdata), 0);
    chk({tag, "_i_ack"}, 64'(i_ack), 0);
    chk({tag, "_d_ack"}, 64'(d_ack), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk_reset_state("rst");
    chk("rst_stall", 64'(stall), 0);
    resetn = 1'b1;
    tick();

    // 1: fetch with minimum latency
    i_req = 1'b1;
    i_addr = 32'h0000_0010;
    push_exp(1'b0, 1'b1, 32'h2002_0005, 1'b0);
    #1;
    chk("t1_stall0", 64'(stall), 1);
    tick();
    chk("t1_m_req", 64'(m_req), 1);
    chk("t1_m_addr", 64'(m_addr), 64'h10);
    chk("t1_m_we", 64'(m_we), 0);
    chk("t1_m_wdata", 64'(m_wdata), 0);
    chk("t1_i_ack_c1", 64'(i_ack), 0);
    m_ack = 1'b1;
    m_rdata = 32'h2002_0005;
    tick();
    m_ack = 1'b0;
    expect_ack("t1");
    chk("t1_m_req_done", 64'(m_req), 0);
    chk("t1_stall2", 64'(stall), 0);
    i_req = 1'b0;
    tick();
    chk("t1_stall3", 64'(stall), 0);
    chk("t1_i_ack_c3", 64'(i_ack), 0);

    // 2: store held until m_ack
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'hCAFE_F00D;
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_m_req", 64'(m_req), 1);
      chk("t2_m_we", 64'(m_we), 1);
      chk("t2_m_addr", 64'(m_addr), 64'h40);
      chk("t2_m_wdata", 64'(m_wdata), 64'hCAFE_F00D);
      chk("t2_d_ack", 64'(d_ack), 0);
      chk("t2_stall", 64'(stall), 1);
      if (k == 3) begin
        m_ack = 1'b1;
        m_rdata = 32'h1234_5678;
      end
      tick();
    end
    m_ack = 1'b0;
    expect_ack("t2");
    chk("t2_m_req_done", 64'(m_req), 0);
    d_req = 1'b0;
    d_we = 1'b0;
    tick();
    chk("t2_d_ack_pulse", 64'(d_ack), 0);

    // 3: simultaneous requests, both priorities
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    i_req = 1'b1;
    i_addr = 32'h100;
    d_req = 1'b1;
    d_addr = 32'h200;
    push_exp(1'b1, 1'b1, 32'hD0D0_0001, 1'b0);
    tick();
    chk("t3_p1_m_addr", 64'(m_addr), 64'h200);
    chk("t3_p0_m_addr", 64'(m_addr0), 64'h100);
    chk("t3_p0_m_we", 64'(m_we0), 0);
    chk("t3_p0_m_wdata", 64'(m_wdata0), 0);
    chk("t3_stall", 64'(stall), 1);
    m_ack = 1'b1;
    m_rdata = 32'hD0D0_0001;
    tick();
    m_ack = 1'b0;
    expect_ack("t3d");
    chk("t3_stall_i_pending", 64'(stall), 1);
    chk("t3_p0_i_ack", 64'(i_ack0), 1);
    chk("t3_p0_d_ack", 64'(d_ack0), 0);
    chk("t3_p0_i_rdata", 64'(i_rdata0), 64'hD0D0_0001);
    chk("t3_p0_stall", 64'(stall0), 1);
    d_req = 1'b0;
    push_exp(1'b0, 1'b1, 32'h1111_2222, 1'b0);
    tick();
    chk("t3_idle_m_req", 64'(m_req), 0);
    chk("t3_idle_stall", 64'(stall), 1);
    tick();
    chk("t3_i_m_req", 64'(m_req), 1);
    chk("t3_i_m_addr", 64'(m_addr), 64'h100);
    m_ack = 1'b1;
    m_rdata = 32'h1111_2222;
    tick();
    m_ack = 1'b0;
    expect_ack("t3i");
    i_req = 1'b0;
    tick();
    chk("t3_stall_end", 64'(stall), 0);

    // 4: delayed m_ack, then spurious m_ack in DONE and IDLE
    i_req = 1'b1;
    i_addr = 32'h24;
    push_exp(1'b0, 1'b1, 32'hABCD_0123, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_m_req", 64'(m_req), 1);
      chk("t4_m_addr", 64'(m_addr), 64'h24);
      chk("t4_m_we", 64'(m_we), 0);
      chk("t4_i_ack", 64'(i_ack), 0);
      tick();
    end
    m_ack = 1'b1;
    m_rdata = 32'hABCD_0123;
    tick();
    expect_ack("t4");
    i_req = 1'b0;
    tick();
    chk("t4_done_spur_i_ack", 64'(i_ack), 0);
    chk("t4_done_spur_m_req", 64'(m_req), 0);
    chk("t4_i_rdata_hold", 64'(i_rdata), 64'hABCD_0123);
    tick();
    chk("t4_idle_spur_m_req", 64'(m_req), 0);
    chk("t4_idle_spur_i_ack", 64'(i_ack), 0);
    chk("t4_idle_spur_d_ack", 64'(d_ack), 0);
    m_ack = 1'b0;

    // 5: reset in BUSY_D drops the transfer
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h80;
    d_wdata = 32'h0000_55AA;
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("t5_busy_m_req", 64'(m_req), 1);
    resetn = 1'b0;
    sb.delete();
    tick();
    chk_reset_state("t5");
    resetn = 1'b1;
    d_req = 1'b0;
    d_we = 1'b0;
    m_ack = 1'b1;
    tick();
    chk("t5_late_m_req", 64'(m_req), 0);
    chk("t5_late_d_ack", 64'(d_ack), 0);
    chk("t5_late_i_ack", 64'(i_ack), 0);
    m_ack = 1'b0;
    i_req = 1'b1;
    i_addr = 32'h30;
    push_exp(1'b0, 1'b1, 32'h0000_0077, 1'b0);
    tick();
    chk("t5_fetch_m_addr", 64'(m_addr), 64'h30);
    m_ack = 1'b1;
    m_rdata = 32'h0000_0077;
    tick();
    m_ack = 1'b0;
    expect_ack("t5");
    i_req = 1'b0;
    tick();

    // 6: memory never answers
    d_req = 1'b1;
    d_addr = 32'h44;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t6_m_req", 64'(m_req), 1);
      chk("t6_d_ack", 64'(d_ack), 0);
      chk("t6_err", 64'(err), 0);
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    push_exp(1'b1, 1'b1, 32'h0, 1'b1);
    expect_ack("t6_to");
    chk("t6_to_m_req", 64'(m_req), 0);
    d_req = 1'b0;
    tick();
    chk("t6_err_clr", 64'(err), 0);
    chk("t6_ack_clr", 64'(d_ack), 0);
`else
    for (int k = 0; k < 4; k++) begin
      chk("t6_hold_m_req", 64'(m_req), 1);
      chk("t6_hold_err", 64'(err), 0);
      chk("t6_hold_d_ack", 64'(d_ack), 0);
      tick();
    end
    push_exp(1'b1, 1'b1, 32'h0000_0066, 1'b0);
    m_ack = 1'b1;
    m_rdata = 32'h0000_0066;
    tick();
    m_ack = 1'b0;
    expect_ack("t6_late");
    d_req = 1'b0;
    tick();
`endif
    chk("end_sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
